// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: frame FSM, LSB-first serializer, parity generator and line driver.
// Optional one-entry holding buffer compiled in with `define UART_TX_HOLD_BUF_EN.
module uart_tx_frame_ctrl #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  accept,
    output logic                  buf_full
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;

    logic                  final_stop;
    logic                  load_frame;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_par_en;
    logic                  load_par_bit;
    logic                  load_stop2;

    // Parity over the payload; odd parity is the inverted even result.
    function automatic logic par_calc(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign final_stop = ((state == ST_STOP1) && !stop2_q) || (state == ST_STOP2);

`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_par_en;
    logic                  hold_par_bit;
    logic                  hold_stop2;
    logic                  in_frame;
    logic                  buf_store;

    assign in_frame  = (state == ST_START) || (state == ST_DATA) || (state == ST_PARITY) ||
                       (state == ST_STOP1) || (state == ST_STOP2);
    // At the final stop a full buffer drains into the shifter and may be refilled the same cycle.
    assign buf_store = Data_Valid && in_frame && (final_stop ? buf_full : !buf_full);
    assign accept    = !rst && Data_Valid &&
                       ((state == ST_IDLE) || final_stop || (in_frame && !buf_full));
`else
    assign accept    = !rst && Data_Valid && ((state == ST_IDLE) || final_stop);
    assign buf_full  = 1'b0;
`endif

    always_comb begin
        load_data    = P_DATA;
        load_par_en  = PAR_EN;
        load_par_bit = par_calc(P_DATA, PAR_TYP);
        load_stop2   = STOP2;
        load_frame   = Data_Valid && ((state == ST_IDLE) || final_stop);
`ifdef UART_TX_HOLD_BUF_EN
        if (final_stop && buf_full) begin
            load_data    = hold_data;
            load_par_en  = hold_par_en;
            load_par_bit = hold_par_bit;
            load_stop2   = hold_stop2;
            load_frame   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            TX_OUT    <= IDLE_LEVEL;
            busy      <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
            buf_full     <= 1'b0;
            hold_data    <= '0;
            hold_par_en  <= 1'b0;
            hold_par_bit <= 1'b0;
            hold_stop2   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    busy   <= 1'b0;
                    TX_OUT <= IDLE_LEVEL;
                    if (load_frame) begin
                        state  <= ST_START;
                        TX_OUT <= ~IDLE_LEVEL;
                        busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    state     <= ST_DATA;
                    TX_OUT    <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en_q) begin
                            state  <= ST_PARITY;
                            TX_OUT <= par_bit_q;
                        end else begin
                            state  <= ST_STOP1;
                            TX_OUT <= IDLE_LEVEL;
                        end
                    end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        TX_OUT    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
                ST_PARITY: begin
                    state  <= ST_STOP1;
                    TX_OUT <= IDLE_LEVEL;
                end
                ST_STOP1, ST_STOP2: begin
                    if ((state == ST_STOP1) && stop2_q) begin
                        state  <= ST_STOP2;
                        TX_OUT <= IDLE_LEVEL;
                    end else if (load_frame) begin
                        // Back-to-back: next start bit follows with no idle gap.
                        state  <= ST_START;
                        TX_OUT <= ~IDLE_LEVEL;
                        busy   <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        TX_OUT <= IDLE_LEVEL;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    TX_OUT <= IDLE_LEVEL;
                    busy   <= 1'b0;
                end
            endcase

            if (load_frame) begin
                shift_reg <= load_data;
                par_en_q  <= load_par_en;
                par_bit_q <= load_par_bit;
                stop2_q   <= load_stop2;
            end

`ifdef UART_TX_HOLD_BUF_EN
            if (buf_store) begin
                buf_full     <= 1'b1;
                hold_data    <= P_DATA;
                hold_par_en  <= PAR_EN;
                hold_par_bit <= par_calc(P_DATA, PAR_TYP);
                hold_stop2   <= STOP2;
            end else if (final_stop && buf_full) begin
                buf_full <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed-vector bench for uart_tx_frame_ctrl (DATA_WIDTH=8, IDLE_LEVEL=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic       TX_OUT;
    logic       busy;
    logic       accept;
    logic       buf_full;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .TX_OUT(TX_OUT), .busy(busy), .accept(accept), .buf_full(buf_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Request one frame from idle and check every line bit (bits[i] = i-th cycle on the wire).
    task automatic do_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                            input logic s2, input int len, input logic [15:0] bits,
                            input logic mid_toggle);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Data_Valid = 1'b1;
        @(negedge clk);
        chk({tag, " accept"}, accept, 1'b1);
        chk({tag, " busy_pre"}, busy, 1'b0);
        next_cycle();
        Data_Valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (mid_toggle && i == 3) begin
                PAR_TYP = ~PAR_TYP; STOP2 = ~STOP2; PAR_EN = ~PAR_EN;
            end
            @(negedge clk);
            chk($sformatf("%s tx%0d", tag, i), TX_OUT, bits[i]);
            chk($sformatf("%s busy%0d", tag, i), busy, 1'b1);
            next_cycle();
        end
        @(negedge clk);
        chk({tag, " busy_post"}, busy, 1'b0);
        chk({tag, " tx_post"}, TX_OUT, 1'b1);
        next_cycle();
    endtask

    initial begin
        rst = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        #12;
        chk("rst tx", TX_OUT, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst accept", accept, 1'b0);
        chk("rst buf_full", buf_full, 1'b0);
        Data_Valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
        do_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 10, 16'h034A, 1'b0);
        // Even then odd parity on 0xA5 (four ones): parity 0 then 1
        do_frame("a5e", 8'hA5, 1'b1, 1'b0, 1'b0, 11, 16'h054A, 1'b0);
        do_frame("a5o", 8'hA5, 1'b1, 1'b1, 1'b0, 11, 16'h074A, 1'b0);
        // 0x01, even parity = 1, two stop bits, config toggled mid-frame
        do_frame("x01", 8'h01, 1'b1, 1'b0, 1'b1, 12, 16'h0E02, 1'b1);

`ifndef UART_TX_HOLD_BUF_EN
        // Data_Valid held: 0x3C then 0xC3 back to back, accept only in the final stop cycle
        begin
            logic [19:0] b2b;
            b2b = {10'h386, 10'h278};
            P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
            @(negedge clk);
            chk("b2b accept0", accept, 1'b1);
            next_cycle();
            for (int i = 0; i < 20; i++) begin
                if (i == 1)  P_DATA = 8'hC3;
                if (i == 10) Data_Valid = 1'b0;
                @(negedge clk);
                chk($sformatf("b2b tx%0d", i), TX_OUT, b2b[i]);
                chk($sformatf("b2b busy%0d", i), busy, 1'b1);
                chk($sformatf("b2b accept%0d", i), accept, (i == 9));
                chk($sformatf("b2b buf_full%0d", i), buf_full, 1'b0);
                next_cycle();
            end
            @(negedge clk);
            chk("b2b busy_post", busy, 1'b0);
            next_cycle();
        end
`else
        // Buffered: 0x55 pulsed at frame cycle 3, second pulse while full is ignored
        begin
            logic [19:0] hb;
            hb = {10'h2AA, 10'h34A};
            P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
            @(negedge clk);
            chk("hb accept0", accept, 1'b1);
            next_cycle();
            Data_Valid = 1'b0;
            for (int i = 0; i < 20; i++) begin
                Data_Valid = (i == 3) || (i == 5);
                P_DATA = (i == 3) ? 8'h55 : 8'h00;
                @(negedge clk);
                chk($sformatf("hb tx%0d", i), TX_OUT, hb[i]);
                chk($sformatf("hb busy%0d", i), busy, 1'b1);
                chk($sformatf("hb accept%0d", i), accept, (i == 3));
                chk($sformatf("hb buf_full%0d", i), buf_full, (i >= 4 && i <= 9));
                next_cycle();
            end
            Data_Valid = 1'b0;
            @(negedge clk);
            chk("hb busy_post", busy, 1'b0);
            next_cycle();
        end
`endif

        // Reset during data bit 4 (frame cycle 5), then a clean frame
        P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
        next_cycle();
        Data_Valid = 1'b0;
        for (int i = 0; i < 5; i++) next_cycle();
        @(negedge clk);
        chk("mid bit4", TX_OUT, 1'b0);
        chk("mid busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("mid rst tx", TX_OUT, 1'b1);
        chk("mid rst busy", busy, 1'b0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        chk("post rst idle tx", TX_OUT, 1'b1);
        do_frame("clean", 8'hA5, 1'b0, 1'b0, 1'b0, 10, 16'h034A, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
